regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the register and data-port width in bits.
REQ-002 Parameter NUM_REGS, default 16, sets the register count; it SHALL be a power of two in the range 2..64.
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS), sets the width of every address port.
REQ-004 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 clear  input  1  synchronous, active-high reset.
REQ-006 rd_a_addr  input  ADDR_W  read port A register select.
REQ-007 rd_a_data  output  DATA_WIDTH  read port A data.
REQ-008 ba_mode  input  1  base-address mode; when high, a port-A read of R0 returns zero.
REQ-009 rd_b_addr  input  ADDR_W  read port B register select.
REQ-010 rd_b_data  output  DATA_WIDTH  read port B data.
REQ-011 wr_en  input  1  write-back strobe.
REQ-012 wr_addr  input  ADDR_W  write-back destination.
REQ-013 wr_data  input  DATA_WIDTH  write-back data.
REQ-014 rsv_en  input  1  reserve-destination strobe, issued when a multi-cycle operation starts.
REQ-015 rsv_addr  input  ADDR_W  register being reserved.
REQ-016 stall_a, stall_b  output  1 each  the addressed register is pending (combinational).
REQ-017 pending  output  NUM_REGS  scoreboard vector; bit n set means Rn awaits write-back.
REQ-018 pend_cnt  output  ADDR_W+1  population count of pending (registered).
REQ-019 rsv_err  output  1  one-cycle registered pulse reporting a reservation conflict.

Function
REQ-020 Write: when wr_en=1 at a rising edge, register[wr_addr] SHALL take wr_data; R0 is writable.
REQ-021 Reads SHALL be combinational, with a write-first bypass: if wr_en=1 and wr_addr equals the read address, rd_x_data SHALL equal wr_data in that cycle.
REQ-022 When ba_mode=1 and rd_a_addr=0, rd_a_data SHALL be all zeros, overriding the bypass; port B is unaffected by ba_mode.
REQ-023 Reserve: rsv_en=1 SHALL set pending[rsv_addr] at the next edge.
REQ-024 Write-back SHALL clear pending[wr_addr] at the next edge.
REQ-025 If rsv_en and wr_en target the same register in the same cycle, pending SHALL remain set (the new reservation wins); the data write still occurs.
REQ-026 If rsv_en targets a register already pending and no write-back to it occurs that cycle, pending SHALL be unchanged and rsv_err SHALL be 1 for exactly the next cycle.
REQ-027 stall_x SHALL equal pending[rd_x_addr] AND NOT (wr_en AND wr_addr==rd_x_addr).
REQ-028 pend_cnt SHALL equal the popcount of the pending value held after the same edge; it never exceeds NUM_REGS.
REQ-029 Reserve and write-back to different registers in the same cycle SHALL both take effect.
REQ-030 Address ports SHALL be used modulo NUM_REGS, with no out-of-range behaviour.

Reset
REQ-031 clear=1 at an edge SHALL zero all registers, pending, pend_cnt and rsv_err.
REQ-032 clear SHALL take priority over a simultaneous wr_en or rsv_en, discarding both.
REQ-033 During the clear cycle, the read outputs SHALL reflect the pre-reset state plus the bypass; from the next cycle they SHALL read 0.

Verification
REQ-034 Reset, then wr R3=0xDEADBEEF -> next cycle rd_a_addr=3 gives 0xDEADBEEF; rd_b_addr=4 gives 0.
REQ-035 Same-cycle wr R5=0x12345678 with rd_a_addr=5 -> rd_a_data=0x12345678 in that cycle (bypass).
REQ-036 R0=0xFFFF0000; ba_mode=1, rd_a_addr=0, rd_b_addr=0 -> rd_a_data=0, rd_b_data=0xFFFF0000.
REQ-037 rsv R7 -> pending[7]=1, pend_cnt=1, stall_a=1 for rd_a_addr=7; wr R7=0x55 -> stall_a=0 in the wr cycle, pending[7]=0 and pend_cnt=0 after the edge.
REQ-038 rsv R2 twice in consecutive cycles -> rsv_err=1 for one cycle, pend_cnt=1; then rsv R2 and wr R2 together -> pending[2] stays 1 and R2 takes the written data.
REQ-039 rsv R1 and R9, then clear together with wr R1=0xAA -> pending=0, pend_cnt=0, R1 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, a write-first
// bypass, a base-address zero override on port A, and a pending-write scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_W-1:0]     rd_a_addr,
  output logic [DATA_WIDTH-1:0] rd_a_data,
  input  logic                  ba_mode,
  input  logic [ADDR_W-1:0]     rd_b_addr,
  output logic [DATA_WIDTH-1:0] rd_b_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  stall_a,
  output logic                  stall_b,
  output logic [NUM_REGS-1:0]   pending,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  rsv_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = ADDR_W + 1;

  // Addresses wrap modulo NUM_REGS (a power of two), so only the low bits select.
  logic [IDX_W-1:0] a_idx, b_idx, w_idx, r_idx;
  assign a_idx = IDX_W'(rd_a_addr);
  assign b_idx = IDX_W'(rd_b_addr);
  assign w_idx = IDX_W'(wr_addr);
  assign r_idx = IDX_W'(rsv_addr);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  err_nxt;
  logic                  a_hit, b_hit;

  assign a_hit = wr_en && (w_idx == a_idx);
  assign b_hit = wr_en && (w_idx == b_idx);

  // Read ports: base-address zero beats the bypass, bypass beats the array.
  always_comb begin
    rd_a_data = regs[a_idx];
    rd_b_data = regs[b_idx];
    if (a_hit) rd_a_data = wr_data;
    if (b_hit) rd_b_data = wr_data;
    if (ba_mode && (a_idx == '0)) rd_a_data = '0;
    stall_a = pending[a_idx] && !a_hit;
    stall_b = pending[b_idx] && !b_hit;
  end

  // Next scoreboard: write-back clears, a new reservation set afterwards wins.
  always_comb begin
    pend_nxt = pending;
    if (wr_en)  pend_nxt[w_idx] = 1'b0;
    if (rsv_en) pend_nxt[r_idx] = 1'b1;
    err_nxt = rsv_en && pending[r_idx] && !(wr_en && (w_idx == r_idx));
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pend_nxt[i]);
    end
  end

  // Register array write; clear zeroes everything and drops the write.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[w_idx] <= wr_data;
    end
  end

  // Scoreboard state, its population count and the conflict pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      pending  <= '0;
      pend_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
      rsv_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        clear;
  logic [3:0]  rd_a_addr, rd_b_addr, wr_addr, rsv_addr;
  logic [31:0] rd_a_data, rd_b_data, wr_data;
  logic        ba_mode, wr_en, rsv_en;
  logic        stall_a, stall_b, rsv_err;
  logic [15:0] pending;
  logic [4:0]  pend_cnt;

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clock(clock), .clear(clear),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .ba_mode(ba_mode),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .stall_a(stall_a), .stall_b(stall_b),
    .pending(pending), .pend_cnt(pend_cnt), .rsv_err(rsv_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks 1 unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; ba_mode = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    step();
    clear = 1'b0;
    #1;
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_cnt", 32'(pend_cnt), 32'h0);
    chk("rst_err", 32'(rsv_err), 32'h0);
    chk("rst_rd_a", rd_a_data, 32'h0);

    // Plain write then read
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0; rd_a_addr = 4'd3; rd_b_addr = 4'd4;
    #1;
    chk("wr3_rd_a", rd_a_data, 32'hDEADBEEF);
    chk("rd4_zero", rd_b_data, 32'h0);

    // Same-cycle bypass
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678; rd_a_addr = 4'd5;
    #1;
    chk("bypass_a", rd_a_data, 32'h12345678);
    chk("bypass_stall", 32'(stall_a), 32'h0);

    // Base-address mode on R0
    step();
    wr_addr = 4'd0; wr_data = 32'hFFFF0000;
    step();
    wr_en = 1'b0; ba_mode = 1'b1; rd_a_addr = 4'd0; rd_b_addr = 4'd0;
    #1;
    chk("ba_rd_a", rd_a_data, 32'h0);
    chk("ba_rd_b", rd_b_data, 32'hFFFF0000);
    ba_mode = 1'b0;
    #1;
    chk("noba_rd_a", rd_a_data, 32'hFFFF0000);
    ba_mode = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1;
    #1;
    chk("ba_over_bypass", rd_a_data, 32'h0);
    chk("ba_b_bypass", rd_b_data, 32'h1);
    wr_en = 1'b0; ba_mode = 1'b0;

    // Reserve R7 and write it back
    rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    rsv_en = 1'b0; rd_a_addr = 4'd7;
    #1;
    chk("rsv7_pending", 32'(pending), 32'h0080);
    chk("rsv7_cnt", 32'(pend_cnt), 32'h1);
    chk("rsv7_stall", 32'(stall_a), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55;
    #1;
    chk("wb7_stall", 32'(stall_a), 32'h0);
    chk("wb7_bypass", rd_a_data, 32'h55);
    step();
    wr_en = 1'b0;
    #1;
    chk("wb7_pending", 32'(pending), 32'h0);
    chk("wb7_cnt", 32'(pend_cnt), 32'h0);
    chk("wb7_rd", rd_a_data, 32'h55);

    // Double reservation of R2
    rsv_en = 1'b1; rsv_addr = 4'd2;
    step();
    #1;
    chk("rsv2_err0", 32'(rsv_err), 32'h0);
    chk("rsv2_pending", 32'(pending), 32'h0004);
    step();
    rsv_en = 1'b0;
    #1;
    chk("rsv2_err1", 32'(rsv_err), 32'h1);
    chk("rsv2_cnt", 32'(pend_cnt), 32'h1);
    chk("rsv2_pend_kept", 32'(pending), 32'h0004);
    step();
    #1;
    chk("rsv2_err_drop", 32'(rsv_err), 32'h0);

    // Reserve and write-back of R2 together
    rsv_en = 1'b1; rsv_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd2;
    wr_data = 32'h0000CAFE; rd_b_addr = 4'd2;
    #1;
    chk("rw2_bypass", rd_b_data, 32'h0000CAFE);
    chk("rw2_stall_b", 32'(stall_b), 32'h0);
    step();
    rsv_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("rw2_pending", 32'(pending), 32'h0004);
    chk("rw2_err", 32'(rsv_err), 32'h0);
    chk("rw2_data", rd_b_data, 32'h0000CAFE);
    chk("rw2_stall_b1", 32'(stall_b), 32'h1);

    // Reserve R9 while writing back R2
    rsv_en = 1'b1; rsv_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h77;
    step();
    wr_en = 1'b0; rsv_addr = 4'd1;
    #1;
    chk("mix_pending", 32'(pending), 32'h0200);
    chk("mix_cnt", 32'(pend_cnt), 32'h1);
    step();
    rsv_en = 1'b0;
    #1;
    chk("r1r9_pending", 32'(pending), 32'h0202);
    chk("r1r9_cnt", 32'(pend_cnt), 32'h2);

    // Clear against a simultaneous write and conflicting reservation
    clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hAA;
    rsv_en = 1'b1; rsv_addr = 4'd9; rd_a_addr = 4'd1; rd_b_addr = 4'd3;
    #1;
    chk("clr_bypass", rd_a_data, 32'hAA);
    chk("clr_pre_b", rd_b_data, 32'hDEADBEEF);
    step();
    clear = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("clr_pending", 32'(pending), 32'h0);
    chk("clr_cnt", 32'(pend_cnt), 32'h0);
    chk("clr_err", 32'(rsv_err), 32'h0);
    chk("clr_r1", rd_a_data, 32'h0);
    chk("clr_r3", rd_b_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
